// File: rtl/rk4_pkg.sv
// rk4_pkg: shared state encoding, default sizes and mux-select constants for the RK4 sequencer
package rk4_pkg;
  localparam int DEF_LAT = 4;
  localparam int DEF_CW = 16;
  localparam logic SEL_INIT = 1'b0;
  localparam logic SEL_FEEDBACK = 1'b1;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    SHOW    = 3'd4,
    FINISH  = 3'd5
  } state_t;
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: 2-flop button synchronizer with rising-edge detect, one pulse per press
module btn_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);
  logic [2:0] s;
  always_ff @(posedge clk)
    s <= !rst_n ? 3'b000 : {s[1:0], btn};
  assign rise = s[1] & ~s[2];
endmodule

// File: rtl/rk4_sequencer.sv
// rk4_sequencer: RK4 datapath controller (load, STEPS x LAT run, capture, show); RK4_SEQ_BTN_SYNC_EN adds button sync/edge detect
module rk4_sequencer
  import rk4_pkg::*;
#(
  parameter int LAT = DEF_LAT,
  parameter int CW  = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          restart,
  input  logic [CW-1:0] steps,
  output logic          sel,
  output logic          clr,
  output logic          ld,
  output logic          ld_disp,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] step_idx
);
  localparam int NW = CW + 3;
  localparam logic [NW-1:0] LAST = NW'(LAT - 1);
  state_t state;
  logic [NW-1:0] cnt;
  logic [CW-1:0] n_reg;
  logic clr_q, start_acc, restart_acc, wrap;
`ifdef RK4_SEQ_BTN_SYNC_EN
  btn_edge_sync u_start_sync (.clk(clk), .rst_n(rst_n), .btn(start), .rise(start_acc));
  btn_edge_sync u_restart_sync (.clk(clk), .rst_n(rst_n), .btn(restart), .rise(restart_acc));
`else
  assign start_acc = start;
  assign restart_acc = restart;
`endif
  assign wrap = cnt == LAST;
  // restart dominates everything except reset, so a same-cycle start is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      step_idx <= '0;
      n_reg <= '0;
      clr_q <= 1'b0;
    end else if (restart_acc) begin
      state <= IDLE;
      cnt <= '0;
      step_idx <= '0;
      clr_q <= 1'b1;
    end else begin
      clr_q <= 1'b0;
      case (state)
        IDLE: if (start_acc) begin
          n_reg <= steps;
          cnt <= '0;
          step_idx <= '0;
          state <= LOAD;
        end
        LOAD: begin
          cnt <= wrap ? '0 : cnt + NW'(1);
          if (wrap) state <= n_reg == '0 ? CAPTURE : RUN;
        end
        RUN: begin
          cnt <= wrap ? '0 : cnt + NW'(1);
          if (wrap && step_idx != n_reg) step_idx <= step_idx + CW'(1);
          if (wrap && step_idx == n_reg - CW'(1)) state <= CAPTURE;
        end
        CAPTURE: state <= SHOW;
        SHOW: state <= FINISH;
        default: state <= state;
      endcase
    end
  end
  assign sel = (state == RUN || state == CAPTURE) ? SEL_FEEDBACK : SEL_INIT;
  assign clr = clr_q;
  assign ld = state == CAPTURE;
  assign ld_disp = state == SHOW;
  assign busy = state == LOAD || state == RUN || state == CAPTURE || state == SHOW;
  assign done = state == FINISH;
endmodule

// File: tb/tb_rk4_sequencer.sv
// tb_rk4_sequencer: directed plus random stimulus against an elapsed-time reference model of the sequence
module tb_rk4_sequencer;
  localparam int LAT = 4;
  localparam int CW = 16;
  logic clk, rst_n, start, restart, sel, clr, ld, ld_disp, busy, done;
  logic [CW-1:0] steps, step_idx;
  int total = 0, bad = 0;
  bit active = 0, clr_e = 0;
  int k = 0, n = 0;
  bit sh1 = 0, sh2 = 0, sh3 = 0, rh1 = 0, rh2 = 0, rh3 = 0;
  rk4_sequencer #(.LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .restart(restart), .steps(steps),
    .sel(sel), .clr(clr), .ld(ld), .ld_disp(ld_disp), .busy(busy), .done(done),
    .step_idx(step_idx)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask
  // phase follows purely from cycles elapsed since the accepted start: 0 idle,1 load,2 run,3 capture,4 show,5 finish
  task automatic tick(input bit st, input bit rs, input bit rn, input int stp);
    bit sa, ra;
    int ph, ei;
    start = st;
    restart = rs;
    rst_n = rn;
    steps = stp[CW-1:0];
    @(posedge clk);
`ifdef RK4_SEQ_BTN_SYNC_EN
    sa = sh2 & ~sh3;
    ra = rh2 & ~rh3;
    if (!rn) {sh1, sh2, sh3, rh1, rh2, rh3} = '0;
    else begin
      {sh3, sh2, sh1} = {sh2, sh1, st};
      {rh3, rh2, rh1} = {rh2, rh1, rs};
    end
`else
    sa = st;
    ra = rs;
`endif
    if (!rn) begin
      active = 0;
      clr_e = 0;
    end else if (ra) begin
      active = 0;
      clr_e = 1;
    end else begin
      clr_e = 0;
      if (active) begin
        if (k < 1000000) k++;
      end else if (sa) begin
        active = 1;
        k = 1;
        n = stp;
      end
    end
    if (!active) ph = 0;
    else if (k <= LAT) ph = 1;
    else if (k <= LAT + n * LAT) ph = 2;
    else if (k == LAT + n * LAT + 1) ph = 3;
    else if (k == LAT + n * LAT + 2) ph = 4;
    else ph = 5;
    ei = ph <= 1 ? 0 : ph == 2 ? (k - LAT - 1) / LAT : n;
    #1;
    if (ph != 4) chk("sel", sel, ph == 2 || ph == 3);
    chk("clr", clr, clr_e);
    chk("ld", ld, ph == 3);
    chk("ld_disp", ld_disp, ph == 4);
    chk("busy", busy, ph >= 1 && ph <= 4);
    chk("done", done, ph == 5);
    chk("step_idx", step_idx, ei);
  endtask
  initial begin
    start = 0;
    restart = 0;
    rst_n = 0;
    steps = '0;
    repeat (2) tick(0, 0, 0, 10);
    repeat (3) tick(0, 0, 1, 10);
    tick(1, 0, 1, 10);
    repeat (55) tick(0, 0, 1, 10);
    tick(0, 1, 1, 0);
    tick(1, 0, 1, 0);
    repeat (12) tick(0, 0, 1, 0);
    tick(0, 1, 1, 8);
    tick(1, 0, 1, 8);
    repeat (LAT + 3 * LAT + 2) tick(0, 0, 1, 8);
    tick(0, 1, 1, 8);
    repeat (4) tick(0, 0, 1, 2);
    tick(1, 0, 1, 2);
    repeat (20) tick(0, 0, 1, 2);
    tick(0, 1, 1, 5);
    tick(1, 1, 1, 5);
    repeat (6) tick(0, 0, 1, 5);
    repeat (30) tick(1, 0, 1, 1);
    repeat (3) tick(0, 0, 1, 1);
    tick(0, 1, 1, 3);
    repeat (3) tick(0, 0, 1, 3);
    tick(1, 0, 1, 3);
    repeat (LAT + 3 * LAT + 3) tick(0, 0, 1, 3);
    tick(0, 0, 0, 3);
    repeat (10) tick(0, 0, 1, 3);
    for (int i = 0; i < 3000; i++)
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0,
           $urandom_range(0, 299) != 0, $urandom_range(0, 9));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rk4_sequencer.md
# rk4_sequencer

Controller for the fixed-point RK4 datapath. It takes the start and restart button requests and forces the initial conditions into the x/y input muxes while the pipeline fills. It then runs exactly STEPS iterations of LAT cycles each, pulses the final-value register load, and then pulses the display-register load. It replaces the separate FSM, step counter and limit comparator around the datapath, and it sits between the board buttons and the datapath control pins, clocked by the slow divided clock.

## Interface
Parameters:
- LAT, 4, datapath cycles per RK4 iteration (shift-register depth)
- CW, 16, width of step count and STEP_IDX

Ports:
- CLK  in  1  slow datapath clock
- RST_N  in  1  synchronous, active-low reset
- START  in  1  start request (center button)
- RESTART  in  1  restart request (right button)
- STEPS  in  CW  number of iterations N; sampled on accepted START
- SEL  out  1  input mux select; 0 = initial x0/y0, 1 = fed-back x/y
- CLR  out  1  one-cycle clear of final-value register
- LD  out  1  one-cycle load of final-value register
- LD_DISP  out  1  one-cycle load of hex display registers
- BUSY  out  1  high in LOAD, RUN, CAPTURE, SHOW
- DONE  out  1  high in FINISH
- STEP_IDX  out  CW  completed iterations in current run

## Operation
- States: IDLE, LOAD, RUN, CAPTURE, SHOW, FINISH.
- IDLE:
  - SEL=0; all pulses low.
  - An accepted START latches STEPS into n_reg, clears the cycle counter and STEP_IDX, and goes to LOAD.
- LOAD:
  - SEL=0 for exactly LAT cycles, so x0/y0 fill the pipeline.
  - If n_reg==0, go to CAPTURE; otherwise go to RUN.
- RUN:
  - SEL=1.
  - The cycle counter increments every cycle. When it wraps from LAT-1 to 0, STEP_IDX increments.
  - When STEP_IDX reaches n_reg-1 and the counter is at LAT-1 (total n_reg*LAT RUN cycles), go to CAPTURE.
- CAPTURE:
  - LD=1 for one cycle; SEL stays 1.
  - STEP_IDX equals n_reg on entry from RUN.
  - Go to SHOW.
- SHOW: LD_DISP=1 for one cycle, then go to FINISH.
- FINISH:
  - DONE=1; SEL=0; hold until RESTART.
  - START is ignored.
- RESTART:
  - Accepted RESTART in any state produces CLR=1 for one cycle and a transition to IDLE.
  - It also clears STEP_IDX and the counter.
  - The display registers are not touched.
- Simultaneous START and RESTART in the same cycle: RESTART wins; START is dropped and must be reasserted.
- START is ignored outside IDLE. RESTART in IDLE still pulses CLR.
- STEP_IDX saturates at n_reg and never wraps. The counter is CW+3 bits wide, so LAT up to 8 and STEPS up to 2^CW-1 do not overflow.

## Timing
- Reset: state=IDLE, SEL=0, CLR=0, LD=0, LD_DISP=0, BUSY=0, DONE=0, STEP_IDX=0, internal counters=0. A reset asserted mid-run aborts on the next edge with no LD.
- All outputs are registered (Moore); they change one cycle after the causing edge.
- START accepted at edge t gives LOAD during cycles t+1..t+LAT.
- RUN during t+LAT+1..t+LAT+n_reg*LAT.
- LD at t+LAT+n_reg*LAT+1.
- LD_DISP at the following cycle.
- DONE from the cycle after that.
- Total START-to-DONE latency: (n_reg+1)*LAT+3 cycles.

## Configuration
- RK4_SEQ_BTN_SYNC_EN defined:
  - START and RESTART each pass through a 2-flop synchronizer plus rising-edge detector.
  - Each press counts once; a held button does not retrigger.
  - Acceptance is delayed by 2 cycles versus the raw pin.
- Undefined: START and RESTART are treated as already-synchronous, level-sampled requests, accepted on any cycle they are high in a state that accepts them.

## Structure
- Shared package rk4_pkg:
  - state enum (IDLE..FINISH)
  - default LAT=4 and CW=16 constants
  - the SEL encoding constants SEL_INIT=0 and SEL_FEEDBACK=1
- One sub-module: btn_edge_sync, the 2-flop synchronizer plus rising-edge detector. It is instantiated twice, only under RK4_SEQ_BTN_SYNC_EN.
- The counter and comparator are internal; no separate counter module.

## Test plan
- Reset, STEPS=10, LAT=4, START pulse at cycle 5:
  - SEL=0 for cycles 6–9, then SEL=1 for cycles 10–49.
  - LD at 50, LD_DISP at 51, DONE from 52.
  - STEP_IDX=10.
- STEPS=0 with START:
  - LOAD for 4 cycles, then LD with no RUN cycles.
  - STEP_IDX=0; DONE 7 cycles after the accepted START.
- RESTART mid-RUN (STEP_IDX=3):
  - CLR for one cycle, then IDLE with STEP_IDX=0.
  - No LD or LD_DISP pulse.
  - A new START runs a full sequence.
- START and RESTART in the same cycle from IDLE: CLR pulse, stay in IDLE, BUSY stays 0.
- START held high through the run, then while DONE=1:
  - Without the macro, the held START causes no second run while in FINISH.
  - With the macro, a held button gives exactly one run, and DONE persists until RESTART.
- RST_N low during SHOW: next cycle all outputs at reset values; LD_DISP does not repeat after release.
